// File: rtl/sram_port_ctrl_if.sv
// Request/response bundle between a master and the SRAM port controller.
// Latency: none (wires only).
// Backpressure: req_ready gates requests, rsp_ready gates responses.
//
// Signals:
//   req_valid/req_ready  request handshake; req_we 1 = write, 0 = read
//   req_addr/req_wdata   word address and write data
//   rsp_valid/rsp_ready  read-response handshake; rsp_rdata in request order
interface sram_port_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    // Requester side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_port_ctrl.sv
// Valid/ready front end for a single-port RW SRAM macro with an in-order read-response FIFO.
// Latency: read fire to rsp_valid is 2 cycles; writes produce no response.
// Backpressure: req_ready is a registered credit check (reads in flight + queued < RSP_DEPTH),
//   so a stalled consumer can never overflow the response FIFO.
//
// Ports:
//   clk0, rstb0        clock shared with the macro; async active-low reset
//   bus (slave)        request/response handshake bundle
//   sram_csb0/web0     macro chip/write enables (active low), driven combinationally
//   sram_addr0/din0    macro address and write data, straight from the request
//   sram_dout0         macro read data, captured one edge after the read was sampled
module sram_port_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    sram_port_ctrl_if.slave       bus,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic                  w_req_ready;
    logic                  w_fire;
    logic                  w_rd_fire;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rsp_vld;

    logic                  r_rd_pend;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_outstanding;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check uses only registered state, so there is no path from
    // rsp_ready or req_valid into req_ready. rstb0 is in the term so the
    // first request can fire on the first edge after release.
    assign w_req_ready = rstb0 && (r_outstanding < CW'(RSP_DEPTH));
    assign w_fire      = bus.req_valid && w_req_ready;
    assign w_rd_fire   = w_fire && !bus.req_we;

    // The macro samples these on the same edge that completes the handshake.
    assign sram_csb0   = !w_fire;
    assign sram_web0   = !(rstb0 && bus.req_we);
    assign sram_addr0  = bus.req_addr;
    assign sram_din0   = bus.req_wdata;

    // dout0 settles after the negedge following the read edge; it is still
    // valid just before the next posedge, which is where it is pushed.
    assign w_push      = r_rd_pend;
    assign w_rsp_vld   = (r_count != '0);
    assign w_pop       = w_rsp_vld && bus.rsp_ready;

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_vld;
    // Head entry is masked while empty so a flushed FIFO shows zero.
    assign bus.rsp_rdata = w_rsp_vld ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_fire;
        end
    end

    always_ff @(posedge clk0) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sram_dout0;
        end
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A credit is taken at read fire and returned when the data leaves.
            unique case ({w_rd_fire, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Credits make overflow unreachable; flag it if it ever happens.
    a_no_overflow: assert property (@(posedge clk0) disable iff (!rstb0)
        !(w_push && (r_count == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_sram_port_ctrl.sv
module tb_sram_port_ctrl;
    logic clk0 = 1'b0;
    logic rstb0;
    always #5 clk0 = ~clk0;

    sram_port_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) bus_a ();
    sram_port_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) bus_b ();

    logic       csb_a, web_a, csb_b, web_b;
    logic [8:0] addr0_a, addr0_b;
    logic [7:0] din0_a, din0_b, dout_a, dout_b;

    sram_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .RSP_DEPTH(4)) u_dut_a (
        .clk0(clk0), .rstb0(rstb0), .bus(bus_a),
        .sram_csb0(csb_a), .sram_web0(web_a), .sram_addr0(addr0_a),
        .sram_din0(din0_a), .sram_dout0(dout_a)
    );

    sram_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .RSP_DEPTH(2)) u_dut_b (
        .clk0(clk0), .rstb0(rstb0), .bus(bus_b),
        .sram_csb0(csb_b), .sram_web0(web_b), .sram_addr0(addr0_b),
        .sram_din0(din0_b), .sram_dout0(dout_b)
    );

    // Macro models: controls captured before the sampling posedge, acted on
    // at the following negedge (write commit / read data out).
    logic [7:0] mem_a [512];
    logic       pv_a, pw_a;
    logic [8:0] pa_a;
    logic [7:0] pd_a;
    always @(negedge clk0) begin
        if (pv_a === 1'b1) begin
            if (pw_a) mem_a[pa_a] = pd_a;
            else      dout_a = mem_a[pa_a];
        end
        pv_a = !csb_a; pw_a = !web_a; pa_a = addr0_a; pd_a = din0_a;
    end

    logic [7:0] mem_b [512];
    logic       pv_b, pw_b;
    logic [8:0] pa_b;
    logic [7:0] pd_b;
    always @(negedge clk0) begin
        if (pv_b === 1'b1) begin
            if (pw_b) mem_b[pa_b] = pd_b;
            else      dout_b = mem_b[pa_b];
        end
        pv_b = !csb_b; pw_b = !web_b; pa_b = addr0_b; pd_b = din0_b;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard state
    logic [7:0] ref_a [512];
    logic [7:0] ref_b [512];
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    logic [7:0] log_a [$];
    int fires_a = 0, pops_a = 0, fires_b = 0, pops_b = 0;

    typedef struct {
        logic       vld;
        logic       we;
        logic [8:0] a;
        logic [7:0] d;
        logic       rdy;
        logic       csb;
        logic       web;
    } vec_t;
    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon_step();
        logic [7:0] e;
        if (!rstb0) begin
            exp_a.delete();
            exp_b.delete();
        end else begin
            if (bus_a.rsp_valid && bus_a.rsp_ready) begin
                pops_a++;
                log_a.push_back(bus_a.rsp_rdata);
                if (exp_a.size() == 0) chk("rsp_a_unexpected", 32'(bus_a.rsp_rdata), 32'hFFFF_FFFF);
                else begin e = exp_a.pop_front(); chk("rsp_a_data", 32'(bus_a.rsp_rdata), 32'(e)); end
            end
            if (bus_a.req_valid && bus_a.req_ready) begin
                fires_a++;
                if (bus_a.req_we) ref_a[bus_a.req_addr] = bus_a.req_wdata;
                else exp_a.push_back(ref_a[bus_a.req_addr]);
            end
            if (bus_b.rsp_valid && bus_b.rsp_ready) begin
                pops_b++;
                if (exp_b.size() == 0) chk("rsp_b_unexpected", 32'(bus_b.rsp_rdata), 32'hFFFF_FFFF);
                else begin e = exp_b.pop_front(); chk("rsp_b_data", 32'(bus_b.rsp_rdata), 32'(e)); end
            end
            if (bus_b.req_valid && bus_b.req_ready) begin
                fires_b++;
                if (bus_b.req_we) ref_b[bus_b.req_addr] = bus_b.req_wdata;
                else exp_b.push_back(ref_b[bus_b.req_addr]);
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic issue(input bit sel, input logic we, input logic [8:0] a,
                         input logic [7:0] d, output bit stalled);
        bit done;
        done = 1'b0;
        stalled = 1'b0;
        if (sel) begin
            bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_addr = a; bus_b.req_wdata = d;
        end else begin
            bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_addr = a; bus_a.req_wdata = d;
        end
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk0);
            if (sel ? bus_b.req_ready : bus_a.req_ready) begin
                @(posedge clk0); #1;
                done = 1'b1;
            end else begin
                stalled = 1'b1;
            end
        end
        if (sel) bus_b.req_valid = 1'b0; else bus_a.req_valid = 1'b0;
        chk("issue_handshake", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (exp_a.size() != 0 || exp_b.size() != 0); k++) @(posedge clk0);
        @(posedge clk0); #1;
        chk("drain_a_empty", exp_a.size(), 0);
        chk("drain_b_empty", exp_b.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit st;
        int stalls, f0, p0, lat, quiet, n;
        logic [8:0] ab;
        logic f;

        vt[0] = '{1'b1, 1'b1, 9'h005, 8'hA5, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 9'h005, 8'h00, 1'b1, 1'b1, 1'b1};
        vt[2] = '{1'b1, 1'b0, 9'h005, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[3] = '{1'b0, 1'b1, 9'h0AA, 8'h5A, 1'b1, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b1, 9'h1FF, 8'h33, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b0, 9'h1FF, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[6] = '{1'b1, 1'b1, 9'h100, 8'hC3, 1'b1, 1'b0, 1'b0};

        fork
            forever begin @(negedge clk0); mon_step(); end
        join_none

        // Reset: drive an active write request to show outputs are forced idle.
        rstb0 = 1'b0;
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 9'h005;
        bus_a.req_wdata = 8'hFF; bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
        bus_b.req_wdata = '0; bus_b.rsp_ready = 1'b1;
        repeat (3) @(negedge clk0);
        chk("rst_req_ready", 32'(bus_a.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(bus_a.rsp_rdata), 0);
        chk("rst_csb", 32'(csb_a), 1);
        chk("rst_web", 32'(web_a), 1);
        bus_a.req_valid = 1'b0;
        @(negedge clk0);
        rstb0 = 1'b1;
        #1;
        chk("rel_req_ready", 32'(bus_a.req_ready), 1);
        @(posedge clk0); #1;

        // Macro-drive vectors, one request each, idle in between.
        for (int i = 0; i < 7; i++) begin
            bus_a.req_valid = vt[i].vld; bus_a.req_we = vt[i].we;
            bus_a.req_addr = vt[i].a; bus_a.req_wdata = vt[i].d;
            @(negedge clk0);
            chk("vec_ready", 32'(bus_a.req_ready), 32'(vt[i].rdy));
            chk("vec_csb", 32'(csb_a), 32'(vt[i].csb));
            chk("vec_web", 32'(web_a), 32'(vt[i].web));
            chk("vec_addr0", 32'(addr0_a), 32'(vt[i].a));
            chk("vec_din0", 32'(din0_a), 32'(vt[i].d));
            @(posedge clk0); #1;
            bus_a.req_valid = 1'b0;
            @(negedge clk0);
            chk("vec_csb_one_cycle", 32'(csb_a), 1);
            repeat (3) @(posedge clk0);
            #1;
        end
        drain();

        // Read latency and single response.
        p0 = pops_a;
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 9'h005;
        @(posedge clk0); #1;
        bus_a.req_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk0);
            if (bus_a.rsp_valid) break;
            @(posedge clk0);
            lat++;
        end
        chk("read_latency", lat, 2);
        chk("read_data_a5", 32'(bus_a.rsp_rdata), 32'hA5);
        repeat (5) @(posedge clk0);
        #1;
        chk("single_response", pops_a - p0, 1);

        // Pre-write 0x00..0x1F with addr ^ 0x3C, then 16 back-to-back reads.
        for (int i = 0; i < 32; i++) issue(1'b0, 1'b1, 9'(i), 8'(i) ^ 8'h3C, st);
        stalls = 0;
        p0 = pops_a;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 1'b0, 9'(i), 8'h00, st);
            if (st) stalls++;
        end
        drain();
        chk("b2b_no_stall", stalls, 0);
        chk("b2b_16_rsp", pops_a - p0, 16);

        // Credit exhaustion with consumer stalled.
        bus_a.rsp_ready = 1'b0;
        f0 = fires_a;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b0, 9'h010 + 9'(i), 8'h00, st);
            if (st) stalls++;
        end
        chk("credit_4_no_stall", stalls, 0);
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 9'h014;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk0);
            chk("credit_ready_low", 32'(bus_a.req_ready), 0);
        end
        @(posedge clk0); #1;
        p0 = pops_a;
        bus_a.rsp_ready = 1'b1;
        @(posedge clk0); #1;
        bus_a.rsp_ready = 1'b0;
        chk("credit_one_pop", pops_a - p0, 1);
        @(negedge clk0);
        chk("credit_ready_back", 32'(bus_a.req_ready), 1);
        @(posedge clk0); #1;
        bus_a.req_valid = 1'b0;
        @(negedge clk0);
        chk("credit_ready_low_again", 32'(bus_a.req_ready), 0);
        @(posedge clk0); #1;
        chk("credit_fires", fires_a - f0, 5);
        bus_a.rsp_ready = 1'b1;
        drain();

        // Write/read/write/read on one address.
        issue(1'b0, 1'b1, 9'h1FF, 8'h11, st);
        issue(1'b0, 1'b0, 9'h1FF, 8'h00, st);
        issue(1'b0, 1'b1, 9'h1FF, 8'h22, st);
        issue(1'b0, 1'b0, 9'h1FF, 8'h00, st);
        drain();
        n = log_a.size();
        chk("wrwr_first", 32'(log_a[n-2]), 32'h11);
        chk("wrwr_second", 32'(log_a[n-1]), 32'h22);

        // Reset with two responses queued and one read in flight.
        issue(1'b0, 1'b1, 9'h005, 8'hA5, st);
        bus_a.rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 9'h001, 8'h00, st);
        issue(1'b0, 1'b0, 9'h002, 8'h00, st);
        issue(1'b0, 1'b0, 9'h003, 8'h00, st);
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 9'h004;
        rstb0 = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(bus_a.rsp_valid), 0);
        chk("midrst_csb", 32'(csb_a), 1);
        chk("midrst_req_ready", 32'(bus_a.req_ready), 0);
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        bus_a.req_valid = 1'b0;
        bus_a.rsp_ready = 1'b1;
        rstb0 = 1'b1;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk0);
            if (bus_a.rsp_valid) quiet++;
        end
        chk("midrst_no_stale", quiet, 0);
        @(posedge clk0); #1;
        issue(1'b0, 1'b0, 9'h005, 8'h00, st);
        drain();
        n = log_a.size();
        chk("midrst_retained", 32'(log_a[n-1]), 32'hA5);

        // Depth-2 instance: 2 fires per 3 cycles under continuous reads.
        for (int i = 0; i < 12; i++) issue(1'b1, 1'b1, 9'(i), 8'(i) ^ 8'h3C, st);
        ab = '0;
        f0 = fires_b;
        p0 = pops_b;
        bus_b.req_valid = 1'b1; bus_b.req_we = 1'b0; bus_b.req_addr = ab;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk0);
            f = bus_b.req_ready;
            chk("d2_fire_pattern", 32'(f), 32'((c % 3) != 2));
            @(posedge clk0); #1;
            if (f) begin ab = ab + 9'd1; bus_b.req_addr = ab; end
        end
        bus_b.req_valid = 1'b0;
        drain();
        chk("d2_fires", fires_b - f0, 12);
        chk("d2_rsps", pops_b - p0, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Valid/ready front end for the single-port RW SRAM macro (DATA_WIDTH 8, ADDR_WIDTH 9, 512 words).
- Converts a request stream (read/write) into csb0/web0/addr0/din0 and captures dout0 on the correct edge.
- Returns read data through a credit-protected response FIFO, so downstream backpressure never loses read data.
- Sits directly upstream of the macro; masters see a standard handshake instead of raw macro timing.

Parameters:
DATA_WIDTH, 8, word width; matches macro.
ADDR_WIDTH, 9, address width; matches macro.
RSP_DEPTH, 4, response FIFO entries; must be >= 3 for full read throughput. Legal range 2..16.

Ports:
clk0  in  1  single clock; macro is clocked by the same net.
rstb0  in  1  reset, asynchronous assert, active-low.
req_valid  in  1  request present.
req_ready  out  1  request accepted when valid && ready at posedge clk0.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  word address.
req_wdata  in  DATA_WIDTH  write data.
rsp_valid  out  1  read data available.
rsp_ready  in  1  consumer accepts rsp_rdata.
rsp_rdata  out  DATA_WIDTH  read data, in request order.
sram_csb0  out  1  to macro csb0, active low.
sram_web0  out  1  to macro web0, active low.
sram_addr0  out  ADDR_WIDTH  to macro addr0.
sram_din0  out  DATA_WIDTH  to macro din0.
sram_dout0  in  DATA_WIDTH  from macro dout0.

Behaviour:
- Reset (rstb0 low, async):
  - FIFO empty; outstanding count 0; rd_pend 0.
  - rsp_valid 0, rsp_rdata 0, req_ready 0.
  - sram_csb0 forced 1 combinationally; sram_web0 1.
- fire = req_valid && req_ready.
- req_ready = rstb0 && (outstanding < RSP_DEPTH).
  - outstanding = rd_pend + FIFO occupancy, registered.
  - No combinational path from rsp_ready or req_valid to req_ready.
  - Writes also wait for a credit (ready is payload-independent).
- Macro drive is combinational from the request:
  - sram_csb0 = !fire.
  - sram_web0 = !req_we.
  - sram_addr0 = req_addr.
  - sram_din0 = req_wdata.
  - The macro samples these at the same posedge that completes the handshake (edge E0).
- Write: committed by the macro at the following negedge. No response generated.
- Read:
  - rd_pend set at E0.
  - Macro dout0 is valid from negedge after E0 plus macro delay until E1.
  - Controller pushes sram_dout0 into the FIFO at E1 using the pre-edge value; rd_pend clears at E1 unless a new read fires at E1.
  - rsp_valid rises in the cycle after E1. Fire-to-rsp_valid latency is 2 cycles.
- FIFO:
  - First-word-fall-through, pointers wrap modulo RSP_DEPTH.
  - rsp_rdata shows the head entry; pop on rsp_valid && rsp_ready.
  - Push and pop in the same edge: occupancy unchanged, data order preserved.
  - Overflow is impossible by credit. Simulation assertion: push when full is an error.
- Outstanding count: +1 on read fire, -1 on pop; both in the same edge means unchanged. A credit freed by a pop is visible the next cycle.
- Ordering follows macro timing:
  - Read then write to the same address in consecutive cycles returns old data.
  - Write then read returns new data.
- Throughput:
  - RSP_DEPTH >= 3 with rsp_ready held 1: one read per cycle.
  - RSP_DEPTH = 2: 2 reads per 3 cycles.
- Reset mid-operation: in-flight read discarded, FIFO flushed, no rsp_valid after release until a new read completes.
- After rstb0 deasserts, req_ready rises combinationally; the first request may fire on the first posedge.

Test Plan:
1. Reset, write addr 0x005 = 0xA5, then read 0x005 -> sram_csb0 low for exactly 1 cycle each; rsp_valid 2 cycles after the read fire; rsp_rdata 0xA5; one response only.
2. Back-to-back reads 0x000..0x00F (pre-written = addr XOR 0x3C), rsp_ready=1, RSP_DEPTH=4 -> req_ready never drops; 16 responses in order; data matches.
3. rsp_ready=0, issue reads -> exactly 4 fire and req_ready falls. Raise rsp_ready for 1 cycle -> one pop; req_ready returns the next cycle; no data lost or duplicated.
4. Write 0x1FF=0x11, read 0x1FF, write 0x1FF=0x22, read 0x1FF, consecutive cycles -> responses 0x11 then 0x22.
5. Assert rstb0 low mid-way through a read (between fire and push), with 2 entries queued -> rsp_valid 0 immediately and sram_csb0 1. After release, no stale response; next read of 0x005 returns 0xA5 (memory contents retained).
6. RSP_DEPTH=2 build, continuous reads, rsp_ready=1 -> 2 fires per 3 cycles; in-order correct data.
